// File: rtl/digit_serial_pkg.sv
// Shared types and constants for the digit-serial add/subtract block.
package digit_serial_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Counter width that stays legal for single-digit words.
  function automatic int cnt_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_add_sub_adder.sv
// Ripple-carry digit adder built from plain logic operators; also exposes the
// carry into the top bit so the caller can derive signed overflow.
module digit_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] c_s;

  // Full-adder chain, LSB to MSB.
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c_s[W];
  assign cmsb = c_s[W-1];

endmodule

// File: rtl/digit_serial_add_sub.sv
// Digit-serial adder/subtractor: LSB-first operands, DIGIT_W bits per beat,
// WORD_DIGITS beats per word, one-deep registered output stage.
module digit_serial_add_sub
  import digit_serial_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int WORD_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sub,
  input  logic [DIGIT_W-1:0] in_a,
  input  logic [DIGIT_W-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT_W-1:0] out_digit,
  output logic               out_last,
  output logic               out_carry,
  output logic               out_ovf
);

  localparam int CNT_W = cnt_width(WORD_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_DIGITS - 1);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               carry_r;
  logic               op_r;

  logic               accept_s;
  logic               first_s;
  logic               last_s;
  logic               sub_s;
  logic               cin_s;
  logic [DIGIT_W-1:0] b_eff_s;
  logic [DIGIT_W-1:0] sum_s;
  logic               cout_s;
  logic               cmsb_s;

  assign in_ready = ~out_valid | out_ready;
  assign accept_s = in_valid & in_ready;

  // First digit takes its op and carry-in straight from the input, so a
  // stale carry from the previous word can never leak in.
  always_comb begin
    first_s = (state_r == IDLE);
    last_s  = (cnt_r == LAST_CNT);
    if (first_s) begin
      sub_s = in_sub;
      cin_s = in_sub;
    end else begin
      sub_s = op_r;
      cin_s = carry_r;
    end
    if (sub_s == OP_SUB) begin
      b_eff_s = ~in_b;
    end else begin
      b_eff_s = in_b;
    end
  end

  digit_adder #(
    .W(DIGIT_W)
  ) u_adder (
    .a   (in_a),
    .b   (b_eff_s),
    .cin (cin_s),
    .s   (sum_s),
    .cout(cout_s),
    .cmsb(cmsb_s)
  );

  // Word framing FSM, carry/op state and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      carry_r   <= 1'b0;
      op_r      <= OP_ADD;
      out_valid <= 1'b0;
      out_digit <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_digit <= sum_s;
      out_last  <= last_s;
      out_carry <= last_s ? cout_s : 1'b0;
      out_ovf   <= last_s ? (cmsb_s ^ cout_s) : 1'b0;
      carry_r   <= cout_s;
      if (first_s) begin
        op_r <= in_sub;
      end else begin
        op_r <= op_r;
      end
      case (state_r)
        IDLE: begin
          if (last_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else begin
            state_r <= RUN;
            cnt_r   <= CNT_W'(1);
          end
        end
        RUN: begin
          if (last_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else begin
            state_r <= RUN;
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Self-checking bench: directed words plus randomized traffic, checked against
// a word-level arithmetic reference model.
module tb_digit_serial_add_sub;

  localparam int DW = 4;
  localparam int WD = 2;
  localparam int WW = DW * WD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sub = 1'b0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_digit;
  logic          out_last;
  logic          out_carry;
  logic          out_ovf;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic          carry;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   digits_expected = 0;
  int   out_count = 0;
  bit   rand_ready = 1'b0;
  bit   forced_ready = 1'b1;
  bit   mon_en = 1'b1;

  digit_serial_add_sub #(
    .DIGIT_W    (DW),
    .WORD_DIGITS(WD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sub   (in_sub),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_digit(out_digit),
    .out_last (out_last),
    .out_carry(out_carry),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: whole-word integer arithmetic, then split into digits.
  task automatic push_word(input logic [WW-1:0] a, input logic [WW-1:0] b, input bit sub);
    int            sum;
    bit            carry;
    bit            ovf;
    logic [WW-1:0] r;
    exp_t          e;
    if (sub) begin
      sum   = int'($signed(a)) - int'($signed(b));
      carry = (a >= b);
      r     = a - b;
    end else begin
      sum   = int'($signed(a)) + int'($signed(b));
      carry = (int'(a) + int'(b)) > ((1 << WW) - 1);
      r     = a + b;
    end
    ovf = (sum > ((1 << (WW - 1)) - 1)) || (sum < -(1 << (WW - 1)));
    for (int i = 0; i < WD; i++) begin
      e.d     = r[DW*i +: DW];
      e.last  = (i == WD - 1);
      e.carry = e.last ? carry : 1'b0;
      e.ovf   = e.last ? ovf : 1'b0;
      exp_q.push_back(e);
      digits_expected++;
    end
  endtask

  task automatic send_digit(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s, input int gap);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = s;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] a, input logic [WW-1:0] b,
                           input bit sub, input bit sub_late, input int max_gap);
    push_word(a, b, sub);
    for (int i = 0; i < WD; i++) begin
      send_digit(a[DW*i +: DW], b[DW*i +: DW], (i == 0) ? sub : sub_late,
                 (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain_empty", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_digit", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("digit", out_digit, e.d);
          check("last", out_last, e.last);
          check("carry", out_carry, e.carry);
          check("ovf", out_ovf, e.ovf);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_digit", out_digit, 32'd0);
    check("rst_out_last", out_last, 32'd0);
    check("rst_out_carry", out_carry, 32'd0);
    check("rst_out_ovf", out_ovf, 32'd0);
    check("rst_in_ready", in_ready, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed words, back-to-back with no gaps.
    send_word(8'h3C, 8'h05, 1'b0, 1'b0, 0);
    send_word(8'h10, 8'h01, 1'b1, 1'b1, 0);
    send_word(8'h01, 8'h02, 1'b1, 1'b1, 0);
    send_word(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    send_word(8'h80, 8'h80, 1'b0, 1'b0, 0);
    send_word(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    send_word(8'h00, 8'h00, 1'b0, 1'b1, 0);
    drain();

    // Backpressure: stall the output after the first result digit.
    forced_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_word(8'h3C, 8'h05, 1'b0);
    send_digit(4'hC, 4'h5, 1'b0, 0);
    in_valid = 1'b1;
    in_a     = 4'h3;
    in_b     = 4'h0;
    in_sub   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 32'd0);
      check("bp_out_valid", out_valid, 32'd1);
      check("bp_hold_digit", out_digit, 32'h1);
      @(posedge clk);
      #1;
    end
    forced_ready = 1'b1;
    send_digit(4'h3, 4'h0, 1'b0, 0);
    drain();
    check("digit_count_bp", out_count, digits_expected);

    // Reset after the first digit of a word aborts it.
    mon_en = 1'b0;
    send_digit(4'hC, 4'h5, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 32'd0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    send_word(8'h12, 8'h34, 1'b0, 1'b0, 0);
    drain();

    // Randomized traffic with random gaps and random backpressure.
    rand_ready = 1'b1;
    for (int w = 0; w < 60; w++) begin
      send_word(WW'($urandom), WW'($urandom), $urandom_range(0, 1) != 0,
                $urandom_range(0, 1) != 0, 2);
    end
    drain();
    check("digit_count_total", out_count, digits_expected);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_serial_add_sub.md
Name: digit_serial_add_sub

Overview:
- Parametrised successor to the bit-serial adder. Adds or subtracts two operands streamed LSB-first, DIGIT_W bits per beat, framed into words of WORD_DIGITS digits.
- Uses valid/ready handshakes on both sides and a 1-deep registered output stage.
- Reports carry/borrow and signed overflow on the last digit of each word.
- Sits between serialising front-ends and digit-serial datapath consumers.

Parameters:
- DIGIT_W, 4, bits processed per beat (>=2).
- WORD_DIGITS, 8, digits per word (>=1). Word width is DIGIT_W*WORD_DIGITS.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; one clock domain
- in_valid  in  1  input digit valid
- in_ready  out  1  block can accept a digit
- in_sub  in  1  operation: 0 = a+b, 1 = a-b; sampled on the first digit of a word only
- in_a  in  DIGIT_W  operand A digit, LSB-first
- in_b  in  DIGIT_W  operand B digit, LSB-first
- out_valid  out  1  result digit valid
- out_ready  in  1  downstream accepts the digit
- out_digit  out  DIGIT_W  result digit
- out_last  out  1  final digit of the word
- out_carry  out  1  add: carry-out. Sub: 1 = no borrow (a>=b unsigned). Zero unless out_last.
- out_ovf  out  1  signed two's-complement overflow. Zero unless out_last.

Behaviour:
- Reset values: out_valid, out_digit, out_last, out_carry, out_ovf = 0. Digit counter = 0, carry = 0, state IDLE.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- in_ready = ~out_valid | out_ready. This is combinational from out_ready; there is no combinational path from in_valid.
- Latency: result digit appears on out_* the cycle after input transfer.
- Output stage: registers load on every input transfer. If out_ready=0 while out_valid=1, all out_* hold stable. On an output transfer with no input transfer, out_valid clears next cycle.
- States:
  - IDLE: counter = 0; the next accepted digit is the first of a word.
  - RUN: mid-word.
  - IDLE->RUN on accepting a first digit when WORD_DIGITS>1.
  - RUN->IDLE on accepting the digit with counter == WORD_DIGITS-1; the counter wraps to 0.
  - If WORD_DIGITS==1, every digit is first and last; the FSM stays in IDLE.
- Op register: latches in_sub on the first digit. Later in_sub values within the word are ignored.
- Digit arithmetic:
  - b_eff = sub ? ~in_b : in_b.
  - c_in = first ? sub : carry_reg.
  - {c_out, out_digit} = in_a + b_eff + c_in.
  - carry_reg <= c_out on each accepted digit.
  - carry_reg never leaks across words, because the first digit ignores it.
- Last digit:
  - out_last = 1, out_carry = c_out.
  - out_ovf = c_msb ^ c_out, where c_msb is the carry into bit DIGIT_W-1 of that digit.
- Digit adder is built only from ^, &, |, ~ (ripple of full adders); no + operator.
- A reset asserted mid-word aborts the word: partial results are discarded and out_valid = 0 next cycle. The next accepted digit starts a new word.
- Simultaneous output drain and input accept in the same cycle is legal and gives full throughput: one digit per cycle.

Decomposition:
- Package digit_serial_pkg:
  - state enum {IDLE, RUN}.
  - op encoding constants OP_ADD=0, OP_SUB=1.
- Sub-module digit_adder #(W):
  - inputs a, b, cin; outputs s, cout, cmsb.
  - ripple full-adder chain in pure logic ops; instantiated once.

Test Plan (DIGIT_W=4, WORD_DIGITS=2; digits listed LSB first):
- Add 0x3C+0x05: a={C,3}, b={5,0}, sub=0 -> out {1,4}, last on 2nd digit, carry=0, ovf=0.
- Sub 0x10-0x01: a={0,1}, b={1,0}, sub=1 -> out {F,0}, carry=1 (no borrow), ovf=0. Then 0x01-0x02 -> out {F,F}, carry=0.
- Overflow: 0x7F+0x01 -> out {0,8}, carry=0, ovf=1. Then 0x80+0x80 -> out {0,0}, carry=1, ovf=1.
- Back-to-back words with no gaps: 0xFF+0x01 -> {0,0} carry=1; next 0x00+0x00 with sub toggled to 1 on its 2nd digit -> {0,0}, carry=0 (no carry leak, op held as add).
- Backpressure: hold out_ready=0 for 3 cycles after the first result digit -> in_ready=0, out_digit held constant, no digit lost or duplicated; stream completes correctly after release.
- Reset mid-word after the first digit of 0x3C+0x05 -> out_valid=0 the next cycle; following word 0x12+0x34 -> out {6,4}, last and flags correct.
